// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode codes, FSM states
// and the burst-eligible mode check.
package usr_pkg;

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHL   = 3'b001;
   localparam logic [2:0] MODE_SHR   = 3'b010;
   localparam logic [2:0] MODE_ROTL  = 3'b011;
   localparam logic [2:0] MODE_ROTR  = 3'b100;
   localparam logic [2:0] MODE_LOAD  = 3'b101;
   localparam logic [2:0] MODE_ASR   = 3'b110;
   localparam logic [2:0] MODE_CLEAR = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Only pure shift/rotate modes may be repeated by the burst sequencer.
   function automatic logic is_shift_mode(input logic [2:0] m);
      return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) ||
             (m == MODE_ROTR) || (m == MODE_ASR);
   endfunction

endpackage

// File: rtl/usr_shift_alu.sv
// Combinational next-value unit shared by the manual and burst paths.
module usr_shift_alu
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] nxt
);

   always_comb begin
      nxt = q;
      case (mode)
         MODE_HOLD:  nxt = q;
         MODE_SHL:   nxt = {q[WIDTH-2:0], sin_l};
         MODE_SHR:   nxt = {sin_r, q[WIDTH-1:1]};
         MODE_ROTL:  nxt = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_ROTR:  nxt = {q[0], q[WIDTH-1:1]};
         MODE_LOAD:  nxt = d;
         MODE_ASR:   nxt = {q[WIDTH-1], q[WIDTH-1:1]};
         MODE_CLEAR: nxt = '0;
         default:    nxt = q;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register with manual modes and an N-shift burst sequencer.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | manual operation; a start with a shift mode launches a burst
//   ST_SHIFT | one burst_mode shift per edge until the counter reaches zero
//   ST_DONE  | done pulse for one cycle, q held, then back to ST_IDLE
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [CNT_W-1:0] shift_cnt,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             sout_msb,
   output logic             sout_lsb,
   output logic             busy,
   output logic             done
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       burst_mode_q, burst_mode_d;
   logic [2:0]       alu_mode;
   logic [WIDTH-1:0] q_r, nxt;

   usr_shift_alu #(.WIDTH(WIDTH)) u_alu (
      .q     (q_r),
      .mode  (alu_mode),
      .d     (d),
      .sin_l (sin_l),
      .sin_r (sin_r),
      .nxt   (nxt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         burst_mode_q <= MODE_HOLD;
         q_r          <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         burst_mode_q <= burst_mode_d;
         q_r          <= nxt;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      burst_mode_d = burst_mode_q;
      alu_mode     = MODE_HOLD;
      case (state_q)
         ST_IDLE: begin
            if (en && start && is_shift_mode(mode)) begin
               // q is left untouched on the accept edge
               burst_mode_d = mode;
               cnt_d        = shift_cnt;
               state_d      = (shift_cnt != '0) ? ST_SHIFT : ST_DONE;
            end else if (en) begin
               alu_mode = mode;
            end
         end
         ST_SHIFT: begin
            alu_mode = burst_mode_q;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
               state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign q        = q_r;
   assign qb       = ~q_r;
   assign sout_msb = q_r[WIDTH-1];
   assign sout_lsb = q_r[0];
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);

endmodule
